// File: rtl/ws2812_multi_strip_driver.sv
// Parallel WS2812 strip driver: streams frame bytes from a synchronous BRAM port,
// scales them by a per-frame brightness and shifts them MSB-first onto NUM_STRIPS pins.
module ws2812_multi_strip_driver #(
   parameter int NUM_STRIPS = 4,
   parameter int NUM_LEDS   = 160,
   parameter int CHANNELS   = 3,
   parameter int ADDR_WIDTH = 13,
   parameter int T_BIT      = 70,
   parameter int T0H        = 20,
   parameter int T1H        = 50,
   parameter int T_RESET    = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  continuous,
   input  logic [7:0]            brightness,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [7:0]            mem_dout,
   output logic [NUM_STRIPS-1:0] strip_do,
   output logic                  busy,
   output logic                  frame_done,
   output logic [1:0]            dbg_state
);

   localparam int B   = NUM_LEDS * CHANNELS;
   localparam int CW  = (T_BIT > 1) ? $clog2(T_BIT) : 1;
   localparam int BYW = $clog2(B + 1);
   localparam int LW  = $clog2(NUM_STRIPS + 2);
   localparam int GW  = $clog2(T_RESET + 1);

   if (NUM_STRIPS + 2 > 8 * T_BIT) begin : g_bad_prefetch
      $error("prefetch window does not fit inside one byte time");
   end
   if (!(T0H > 0 && T0H < T1H && T1H < T_BIT)) begin : g_bad_timing
      $error("pulse timing must satisfy 0 < T0H < T1H < T_BIT");
   end
   if (NUM_STRIPS * B > 2 ** ADDR_WIDTH) begin : g_bad_addr
      $error("frame does not fit in the address space");
   end

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

   state_t                       state_q, state_d;
   logic [CW-1:0]                cnt_q, cnt_d;
   logic [2:0]                   bit_q, bit_d;
   logic [BYW-1:0]               byte_q, byte_d;
   logic [LW-1:0]                load_q, load_d;
   logic [LW-1:0]                pf_q, pf_d;
   logic [GW-1:0]                gap_q, gap_d;
   logic [7:0]                   bri_q, bri_d;
   logic [NUM_STRIPS-1:0][7:0]   shift_q, shift_d;
   logic [NUM_STRIPS-1:0][7:0]   shadow_q, shadow_d;
   logic [ADDR_WIDTH-1:0]        mem_addr_q, mem_addr_d;
   logic [NUM_STRIPS-1:0]        strip_do_q, strip_do_d;
   logic                         busy_q, busy_d;
   logic                         frame_done_q, frame_done_d;
   logic [7:0]                   din_scaled;

   // raw*(bri+1) never exceeds 16 bits, so the upper byte is the scaled value
   assign din_scaled = 8'((16'(mem_dout) * 16'(bri_q) + 16'(mem_dout)) >> 8);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         byte_q       <= '0;
         load_q       <= '0;
         pf_q         <= '0;
         gap_q        <= '0;
         bri_q        <= '0;
         shift_q      <= '0;
         shadow_q     <= '0;
         mem_addr_q   <= '0;
         strip_do_q   <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         byte_q       <= byte_d;
         load_q       <= load_d;
         pf_q         <= pf_d;
         gap_q        <= gap_d;
         bri_q        <= bri_d;
         shift_q      <= shift_d;
         shadow_q     <= shadow_d;
         mem_addr_q   <= mem_addr_d;
         strip_do_q   <= strip_do_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      byte_d     = byte_q;
      load_d     = load_q;
      pf_d       = pf_q;
      gap_d      = gap_q;
      bri_d      = bri_q;
      shift_d    = shift_q;
      shadow_d   = shadow_q;
      mem_addr_d = mem_addr_q;
      strip_do_d = '0;

      case (state_q)
         S_IDLE: begin
            if (start || continuous) begin
               state_d    = S_LOAD;
               bri_d      = brightness;
               load_d     = '0;
               mem_addr_d = '0;
            end
         end
         S_LOAD: begin
            // address for strip s goes out at load s, its data is captured at load s+1
            if (int'(load_q) < NUM_STRIPS - 1)
               mem_addr_d = ADDR_WIDTH'((int'(load_q) + 1) * B);
            for (int s = 0; s < NUM_STRIPS; s++)
               if (int'(load_q) == s + 1) shift_d[s] = din_scaled;
            load_d = load_q + LW'(1);
            if (load_q == LW'(NUM_STRIPS + 1)) begin
               state_d = S_SEND;
               cnt_d   = '0;
               bit_d   = '0;
               byte_d  = '0;
               pf_d    = '0;
            end
         end
         S_SEND: begin
            if (pf_q != '0) begin
               if (int'(pf_q) < NUM_STRIPS)
                  mem_addr_d = ADDR_WIDTH'(int'(pf_q) * B + int'(byte_q) + 1);
               for (int s = 0; s < NUM_STRIPS; s++)
                  if (int'(pf_q) == s + 2) shadow_d[s] = din_scaled;
               pf_d = (pf_q == LW'(NUM_STRIPS + 1)) ? '0 : pf_q + LW'(1);
            end else if (cnt_q == '0 && bit_q == 3'd0 && int'(byte_q) < B - 1) begin
               mem_addr_d = ADDR_WIDTH'(int'(byte_q) + 1);
               pf_d       = LW'(1);
            end

            if (cnt_q == CW'(T_BIT - 1)) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  bit_d = '0;
                  if (byte_q == BYW'(B - 1)) begin
                     state_d = S_GAP;
                     gap_d   = '0;
                  end else begin
                     byte_d  = byte_q + BYW'(1);
                     shift_d = shadow_q;
                  end
               end else begin
                  bit_d = bit_q + 3'd1;
                  for (int s = 0; s < NUM_STRIPS; s++) shift_d[s] = {shift_q[s][6:0], 1'b0};
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_GAP: begin
            if (gap_q == GW'(T_RESET - 1)) begin
               if (continuous) begin
                  state_d    = S_LOAD;
                  bri_d      = brightness;
                  load_d     = '0;
                  mem_addr_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // outputs are registered from next-state values so they line up with state_q
      busy_d       = (state_d != S_IDLE);
      frame_done_d = (state_d == S_GAP) && (gap_d == GW'(T_RESET - 1));
      for (int s = 0; s < NUM_STRIPS; s++)
         strip_do_d[s] = (state_d == S_SEND) &&
                         (int'(cnt_d) < (shift_d[s][7] ? T1H : T0H));
   end

   assign mem_addr   = mem_addr_q;
   assign strip_do   = strip_do_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_ws2812_multi_strip_driver.sv
// Bench for ws2812_multi_strip_driver: random frames checked cycle by cycle against
// a waveform computed directly from memory contents and the pulse timing rules.
module tb_ws2812_multi_strip_driver;

   localparam int NS = 2, NL = 2, CH = 3, AW = 4;
   localparam int TB = 10, T0 = 3, T1 = 7, TR = 20;
   localparam int B        = NL * CH;
   localparam int SEND_CYC = B * 8 * TB;
   localparam int PERIOD   = SEND_CYC + TR + NS + 2;

   logic          clk = 1'b0;
   logic          rst, start, continuous;
   logic [7:0]    brightness;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_dout;
   logic [NS-1:0] strip_do;
   logic          busy, frame_done;
   logic [1:0]    dbg_state;

   logic [7:0]    mem [16];
   int            n_checks = 0, n_fail = 0, cyc = 0;

   logic          addr_log_en = 1'b0;
   logic [AW-1:0] addr_prev;
   logic [AW-1:0] addr_seen [$];
   logic [AW-1:0] exp_q [$];
   int            done_cyc [$];

   ws2812_multi_strip_driver #(
      .NUM_STRIPS(NS), .NUM_LEDS(NL), .CHANNELS(CH), .ADDR_WIDTH(AW),
      .T_BIT(TB), .T0H(T0), .T1H(T1), .T_RESET(TR)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous),
      .brightness(brightness), .mem_addr(mem_addr), .mem_dout(mem_dout),
      .strip_do(strip_do), .busy(busy), .frame_done(frame_done),
      .dbg_state(dbg_state)
   );

   // clock / BRAM model / monitors
   always #5 clk = ~clk;

   always @(posedge clk) begin
      mem_dout <= mem[mem_addr];
      cyc      <= cyc + 1;
   end

   always @(negedge clk) begin
      if (addr_log_en && mem_addr !== addr_prev) begin
         addr_seen.push_back(mem_addr);
         addr_prev = mem_addr;
      end
      if (frame_done === 1'b1) done_cyc.push_back(cyc);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   // reference model
   function automatic logic [7:0] ref_scale(input logic [7:0] raw, input int bri);
      return 8'((int'(raw) * (bri + 1)) / 256);
   endfunction

   function automatic logic [NS-1:0] ref_level(input int idx, input int bri);
      int j = idx / (8 * TB);
      int b = (idx / TB) % 8;
      int t = idx % TB;
      logic [NS-1:0] v;
      logic [7:0] by;
      for (int s = 0; s < NS; s++) begin
         by   = ref_scale(mem[s * B + j], bri);
         v[s] = (t < (by[7 - b] ? T1 : T0));
      end
      return v;
   endfunction

   // driver tasks
   task automatic pulse_start(input int bri);
      @(posedge clk); #1;
      brightness = 8'(bri);
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
   endtask

   // poke_kind 1: start + new brightness mid-frame; 2: drop continuous mid-frame
   task automatic check_frame(input int bri, input bit expect_idle, input int poke_at, input int poke_kind);
      for (int c = 0; c < NS + 2; c++) begin
         @(negedge clk);
         check_eq("load_busy", 32'(busy), 32'd1);
         check_eq("load_do", 32'(strip_do), 32'd0);
      end
      for (int i = 0; i < SEND_CYC; i++) begin
         @(negedge clk);
         check_eq("send_do", 32'(strip_do), 32'(ref_level(i, bri)));
         check_eq("send_busy", 32'(busy), 32'd1);
         if (i == poke_at && poke_kind == 1) begin
            start      = 1'b1;
            brightness = 8'($urandom_range(0, 255));
         end
         if (i == poke_at + 1 && poke_kind == 1) start = 1'b0;
         if (i == poke_at && poke_kind == 2) continuous = 1'b0;
      end
      for (int g = 0; g < TR; g++) begin
         @(negedge clk);
         check_eq("gap_do", 32'(strip_do), 32'd0);
         check_eq("gap_done", 32'(frame_done), 32'(g == TR - 1));
         check_eq("gap_busy", 32'(busy), 32'd1);
      end
      if (expect_idle) begin
         for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check_eq("idle_busy", 32'(busy), 32'd0);
            check_eq("idle_do", 32'(strip_do), 32'd0);
            check_eq("idle_done", 32'(frame_done), 32'd0);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; continuous = 1'b0; brightness = 8'd255;
      for (int a = 0; a < 16; a++) mem[a] = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_do", 32'(strip_do), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(frame_done), 32'd0);
      check_eq("rst_addr", 32'(mem_addr), 32'd0);
      rst = 1'b0;

      // single MSB on strip0, single LSB on strip1; extra start mid-frame is ignored
      mem[0] = 8'h80;
      mem[B] = 8'h01;
      pulse_start(255);
      check_frame(255, 1'b1, 200, 1);

      // full-scale bytes at half brightness
      for (int a = 0; a < NS * B; a++) mem[a] = 8'hFF;
      pulse_start(127);
      check_frame(127, 1'b1, -1, 0);

      // random content and brightness, brightness disturbed mid-frame
      for (int r = 0; r < 3; r++) begin
         int bri;
         for (int a = 0; a < NS * B; a++) mem[a] = 8'($urandom_range(0, 255));
         bri = $urandom_range(0, 255);
         pulse_start(bri);
         check_frame(bri, 1'b1, $urandom_range(0, SEND_CYC - 2), 1);
      end

      // incrementing pattern with address sequence tracking
      for (int a = 0; a < NS * B; a++) mem[a] = 8'(a * 17 + 1);
      exp_q.delete();
      for (int l = 0; l < NL; l++)
         for (int c = 0; c < CH; c++)
            for (int s = 0; s < NS; s++)
               exp_q.push_back(AW'(s * NL * CH + l * CH + c));
      addr_seen.delete();
      addr_prev   = mem_addr;
      addr_log_en = 1'b1;
      pulse_start(255);
      check_frame(255, 1'b1, -1, 0);
      addr_log_en = 1'b0;
      check_eq("addr_count", 32'(addr_seen.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < addr_seen.size(); i++)
         check_eq("addr_seq", 32'(addr_seen[i]), 32'(exp_q[i]));

      // reset during bit 13, then replay from byte 0
      pulse_start(255);
      repeat (NS + 2 + 13 * TB + 4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_eq("midrst_do", 32'(strip_do), 32'd0);
      check_eq("midrst_busy", 32'(busy), 32'd0);
      check_eq("midrst_done", 32'(frame_done), 32'd0);
      rst = 1'b0;
      pulse_start(255);
      check_frame(255, 1'b1, -1, 0);

      // continuous mode for three frames, dropped during the third
      for (int a = 0; a < NS * B; a++) mem[a] = 8'($urandom_range(0, 255));
      done_cyc.delete();
      @(posedge clk); #1;
      brightness = 8'd200;
      continuous = 1'b1;
      @(posedge clk); #1;
      check_frame(200, 1'b0, -1, 0);
      check_frame(200, 1'b0, -1, 0);
      check_frame(200, 1'b1, 100, 2);
      check_eq("cont_done_count", 32'(done_cyc.size()), 32'd3);
      for (int i = 1; i < done_cyc.size(); i++)
         check_eq("cont_spacing", 32'(done_cyc[i] - done_cyc[i - 1]), 32'(PERIOD));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
